// File: rtl/shifter8_pkg.sv
// Shared definitions for the 8-bit shifter: operation codes and datapath widths.
package shifter8_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SHAMT_W = 2;

  // Codes 3'b101..3'b111 are intentionally left unnamed; they decode as hold.
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100
  } op_e;

endpackage

// File: rtl/shifter8_next.sv
// Next-state logic for shifter8: per-amount shift muxes and the final op select.
module shifter8_next
  import shifter8_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] shamt,
  input  logic [7:0] d_in,
  input  logic [7:0] q,
  output logic [7:0] q_next
);

  logic [DATA_W-1:0] w_lsl;
  logic [DATA_W-1:0] w_lsr;
  logic [DATA_W-1:0] w_asr;

  always_comb begin
    w_lsl = q;
    w_lsr = q;
    w_asr = q;
    case (shamt)
      2'd0: begin
        w_lsl = q;
        w_lsr = q;
        w_asr = q;
      end
      2'd1: begin
        w_lsl = {q[6:0], 1'b0};
        w_lsr = {1'b0, q[7:1]};
        w_asr = {q[7], q[7:1]};
      end
      2'd2: begin
        w_lsl = {q[5:0], 2'b00};
        w_lsr = {2'b00, q[7:2]};
        w_asr = {{2{q[7]}}, q[7:2]};
      end
      2'd3: begin
        w_lsl = {q[4:0], 3'b000};
        w_lsr = {3'b000, q[7:3]};
        w_asr = {{3{q[7]}}, q[7:3]};
      end
      default: begin
        w_lsl = q;
        w_lsr = q;
        w_asr = q;
      end
    endcase
  end

  always_comb begin
    q_next = q;
    case (op)
      OP_LOAD: q_next = d_in;
      OP_LSL:  q_next = w_lsl;
      OP_LSR:  q_next = w_lsr;
      OP_ASR:  q_next = w_asr;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/shifter8.sv
// 8-bit shift register: load, logical and arithmetic shifts by 0..3,
// asynchronous active-low clear.
module shifter8
  import shifter8_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] op,
  input  logic [1:0] shamt,
  input  logic [7:0] d_in,
  output logic [7:0] d_out
);

  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] w_q_next;

  shifter8_next u_next (
    .op     (op),
    .shamt  (shamt),
    .d_in   (d_in),
    .q      (r_q),
    .q_next (w_q_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_q <= '0;
    else          r_q <= w_q_next;
  end

  assign d_out = r_q;

endmodule

// File: tb/tb_shifter8.sv
// Scoreboard bench for shifter8: stimulus pushes expected values from an
// arithmetic reference model; a monitor pops and compares after each posedge.
module tb_shifter8;

  logic       clk;
  logic       reset_n;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_in;
  logic [7:0] d_out;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m;
  int         n_vec;
  int         n_err;

  shifter8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .op      (op),
    .shamt   (shamt),
    .d_in    (d_in),
    .d_out   (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: d_out=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference computed with integer arithmetic on the value, not bit slicing.
  function automatic logic [7:0] ref_next(input logic [2:0] o, input int s,
                                          input logic [7:0] dat, input logic [7:0] cur);
    int v;
    int p;
    int sv;
    v = int'(cur);
    p = 1 << s;
    case (o)
      3'd1: return dat;
      3'd2: return 8'((v * p) % 256);
      3'd3: return 8'(v / p);
      3'd4: begin
        sv = (v >= 128) ? v - 256 : v;
        if (sv < 0) sv = (sv - (p - 1)) / p;
        else        sv = sv / p;
        return 8'(sv);
      end
      default: return cur;
    endcase
  endfunction

  task automatic step(input logic [2:0] o, input logic [1:0] s, input logic [7:0] dat,
                      input string name);
    exp_t e;
    @(negedge clk);
    op    = o;
    shamt = s;
    d_in  = dat;
    if (reset_n) m = ref_next(o, int'(s), dat, m);
    else         m = 8'h00;
    e.exp  = m;
    e.name = name;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, d_out, e.exp);
      end
    end
  end

  initial begin : stim
    n_vec   = 0;
    n_err   = 0;
    m       = 8'h00;
    reset_n = 1'b0;
    op      = 3'd1;
    shamt   = 2'd0;
    d_in    = 8'hA5;
    #1;
    check("reset_async", d_out, 8'h00);

    // any op while in reset keeps zero
    step(3'd1, 2'd0, 8'hA5, "reset_load");
    step(3'd2, 2'd1, 8'h3C, "reset_lsl");
    @(negedge clk);
    #2 reset_n = 1'b1;
    step(3'd0, 2'd0, 8'hFF, "nop_after_reset");

    // LOAD then LSL
    step(3'd1, 2'd0, 8'hB8, "load_b8");
    step(3'd2, 2'd0, 8'h00, "lsl0");
    for (int unsigned i = 0; i < 6; i++) step(3'd2, 2'd1, 8'h11, "lsl1_chain");

    // LSR with d_in changing
    step(3'd1, 2'd0, 8'hB8, "load_b8");
    step(3'd3, 2'd1, 8'hFF, "lsr1_a");
    step(3'd3, 2'd1, 8'h01, "lsr1_b");
    step(3'd1, 2'd0, 8'h97, "load_97");
    step(3'd3, 2'd3, 8'hAA, "lsr3_a");
    step(3'd3, 2'd3, 8'h55, "lsr3_b");

    // ASR
    step(3'd1, 2'd0, 8'h97, "load_97");
    step(3'd4, 2'd2, 8'h00, "asr2");
    step(3'd4, 2'd3, 8'h00, "asr3_a");
    step(3'd4, 2'd3, 8'h00, "asr3_sticky");
    step(3'd1, 2'd0, 8'h40, "load_40");
    step(3'd4, 2'd1, 8'hFF, "asr1_zero_fill");

    // unused codes and shamt=0
    step(3'd1, 2'd0, 8'h5A, "load_5a");
    step(3'd5, 2'd1, 8'h00, "op5_hold");
    step(3'd6, 2'd2, 8'h11, "op6_hold");
    step(3'd7, 2'd3, 8'h22, "op7_hold");
    step(3'd2, 2'd0, 8'h33, "lsl_sh0");
    step(3'd3, 2'd0, 8'h44, "lsr_sh0");
    step(3'd4, 2'd0, 8'h55, "asr_sh0");

    // async reset between edges during an ASR run
    step(3'd1, 2'd0, 8'hC3, "load_c3");
    step(3'd4, 2'd1, 8'h00, "asr_pre_reset");
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    m = 8'h00;
    #1;
    check("reset_mid_op", d_out, 8'h00);
    step(3'd4, 2'd1, 8'h00, "asr_in_reset");
    step(3'd1, 2'd0, 8'hEE, "load_in_reset");
    @(posedge clk);
    #2 reset_n = 1'b1;

    // randomized ops
    for (int unsigned i = 0; i < 400; i++)
      step(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom), "random");

    // bounded drain of the scoreboard
    for (int unsigned i = 0; i < 8 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected values left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
